// File: rtl/spi_xfer_seq_if.sv
// spi_xfer_seq_if: request, write/read byte streams and SPI register bus of the sequencer.
interface spi_xfer_seq_if #(
    parameter int LEN_W = 8
);
    logic             req_valid_i;
    logic             req_ready_o;
    logic [7:0]       cmd_i;
    logic             addr_en_i;
    logic [23:0]      addr_i;
    logic [3:0]       dummy_i;
    logic [LEN_W-1:0] wr_len_i;
    logic [LEN_W-1:0] rd_len_i;
    logic [7:0]       wdata_i;
    logic             wvalid_i;
    logic             wready_o;
    logic [7:0]       rdata_o;
    logic             rvalid_o;
    logic             rready_i;
    logic             done_o;
    logic             err_o;
    logic             spi_we_o;
    logic [31:0]      spi_addr_o;
    logic [31:0]      spi_wdata_o;
    logic [31:0]      spi_rdata_i;

    modport master (
        input  req_valid_i, cmd_i, addr_en_i, addr_i, dummy_i, wr_len_i, rd_len_i,
               wdata_i, wvalid_i, rready_i, spi_rdata_i,
        output req_ready_o, wready_o, rdata_o, rvalid_o, done_o, err_o,
               spi_we_o, spi_addr_o, spi_wdata_o
    );

    modport slave (
        output req_valid_i, cmd_i, addr_en_i, addr_i, dummy_i, wr_len_i, rd_len_i,
               wdata_i, wvalid_i, rready_i, spi_rdata_i,
        input  req_ready_o, wready_o, rdata_o, rvalid_o, done_o, err_o,
               spi_we_o, spi_addr_o, spi_wdata_o
    );
endinterface

// File: rtl/spi_xfer_seq.sv
// spi_xfer_seq: runs one chip-select-framed SPI transaction by driving the SPI master registers.
module spi_xfer_seq #(
    parameter logic [7:0] CLK_DIV  = 8'd1,
    parameter logic       CPOL     = 1'b0,
    parameter logic       CPHA     = 1'b0,
    parameter int         LEN_W    = 8,
    parameter int         BUSY_TMO = 1023
) (
    input logic           clk,
    input logic           rst,
    spi_xfer_seq_if.master bus
);
    typedef enum logic [3:0] {
        S_IDLE, S_WWAIT, S_LOAD, S_START, S_BUSY, S_DONEW, S_CAP, S_OUT, S_FIN, S_ABORT, S_DONE
    } state_t;
    typedef enum logic [2:0] {P_CMD, P_ADDR, P_DUM, P_WR, P_RD, P_END} phase_t;

    localparam int TW = $clog2(BUSY_TMO + 2);
    localparam logic [31:0] CTRL_GO  = {16'h0, CLK_DIV, 4'h0, 1'b1, CPHA, CPOL, 1'b1};
    localparam logic [31:0] CTRL_END = {16'h0, CLK_DIV, 4'h0, 1'b0, CPHA, CPOL, 1'b0};

    state_t           state_q, state_d, adv_state;
    phase_t           ph_q, ph_d, nph, adv_ph;
    logic [LEN_W-1:0] cnt_q, cnt_d, adv_cnt;
    logic [LEN_W-1:0] lens [6];
    logic [TW-1:0]    tmo_q, tmo_d;
    logic [23:0]      addr_q;
    logic             addr_en_q;
    logic [3:0]       dummy_q;
    logic [LEN_W-1:0] wr_len_q, rd_len_q;
    logic [7:0]       tx_d, rx_q;
    logic             we_q, done_q, err_q, req_ready_q, rvalid_q, wready_q;
    logic [3:0]       spi_addr_q;
    logic [31:0]      spi_wdata_q;
    logic             unused_rdata;

    // cnt_q holds the bytes still to send in the current phase, including the one in flight
    always_comb begin
        lens[0] = LEN_W'(1);
        lens[1] = addr_en_q ? LEN_W'(3) : '0;
        lens[2] = LEN_W'(dummy_q);
        lens[3] = wr_len_q;
        lens[4] = rd_len_q;
        lens[5] = '0;
        nph = P_END;
        for (int k = 4; k >= 1; k--)
            nph = (k > int'(ph_q) && lens[k] != '0) ? phase_t'(k[2:0]) : nph;
        adv_ph = cnt_q == LEN_W'(1) ? nph : ph_q;
        adv_cnt = cnt_q == LEN_W'(1) ? lens[nph] : cnt_q - LEN_W'(1);
        adv_state = adv_ph == P_END ? S_FIN : (adv_ph == P_WR && !bus.wvalid_i) ? S_WWAIT : S_LOAD;
        state_d = state_q;
        ph_d = ph_q;
        cnt_d = cnt_q;
        tmo_d = tmo_q;
        case (state_q)
            S_IDLE: begin
                state_d = bus.req_valid_i ? S_LOAD : S_IDLE;
                ph_d = P_CMD;
                cnt_d = LEN_W'(1);
            end
            S_WWAIT: state_d = bus.wvalid_i ? S_LOAD : S_WWAIT;
            S_LOAD: state_d = S_START;
            S_START: begin
                state_d = S_BUSY;
                tmo_d = '0;
            end
            S_BUSY: begin
                state_d = bus.spi_rdata_i[0] ? S_DONEW : tmo_q == TW'(BUSY_TMO) ? S_ABORT : S_BUSY;
                tmo_d = tmo_q + TW'(1);
            end
            S_DONEW: state_d = bus.spi_rdata_i[0] ? S_DONEW : S_CAP;
            S_CAP, S_OUT: if ((state_q == S_CAP && ph_q != P_RD) || (state_q == S_OUT && bus.rready_i)) begin
                state_d = adv_state;
                ph_d = adv_ph;
                cnt_d = adv_cnt;
            end else if (state_q == S_CAP) begin
                state_d = S_OUT;
            end
            S_FIN, S_ABORT: state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
        tx_d = ph_d == P_CMD ? bus.cmd_i :
               ph_d == P_WR ? bus.wdata_i :
               ph_d != P_ADDR ? 8'h00 :
               cnt_d == LEN_W'(3) ? addr_q[23:16] :
               cnt_d == LEN_W'(2) ? addr_q[15:8] : addr_q[7:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            ph_q <= P_CMD;
            cnt_q <= '0;
            tmo_q <= '0;
            addr_q <= '0;
            addr_en_q <= 1'b0;
            dummy_q <= '0;
            wr_len_q <= '0;
            rd_len_q <= '0;
            rx_q <= '0;
            we_q <= 1'b0;
            done_q <= 1'b0;
            err_q <= 1'b0;
            req_ready_q <= 1'b1;
            rvalid_q <= 1'b0;
            wready_q <= 1'b0;
            spi_addr_q <= 4'h8;
            spi_wdata_q <= '0;
        end else begin
            state_q <= state_d;
            ph_q <= ph_d;
            cnt_q <= cnt_d;
            tmo_q <= tmo_d;
            if (state_q == S_IDLE && bus.req_valid_i) begin
                addr_q <= bus.addr_i;
                addr_en_q <= bus.addr_en_i;
                dummy_q <= bus.dummy_i;
                wr_len_q <= bus.wr_len_i;
                rd_len_q <= bus.rd_len_i;
            end
            rx_q <= (state_q == S_CAP && ph_q == P_RD) ? bus.spi_rdata_i[7:0] : rx_q;
            we_q <= state_d inside {S_LOAD, S_START, S_FIN, S_ABORT};
            spi_addr_q <= state_d inside {S_LOAD, S_CAP} ? 4'h4 :
                          state_d inside {S_START, S_FIN, S_ABORT} ? 4'h0 : 4'h8;
            spi_wdata_q <= state_d == S_LOAD ? {24'h0, tx_d} :
                           state_d == S_START ? CTRL_GO :
                           state_d inside {S_FIN, S_ABORT} ? CTRL_END : '0;
            done_q <= state_d == S_DONE;
            err_q <= state_q == S_ABORT;
            req_ready_q <= state_d == S_IDLE;
            rvalid_q <= state_d == S_OUT;
            wready_q <= state_d == S_LOAD && ph_d == P_WR;
        end
    end

    assign unused_rdata     = ^bus.spi_rdata_i[31:8];
    assign bus.req_ready_o  = req_ready_q;
    assign bus.wready_o     = wready_q;
    assign bus.rdata_o      = rx_q;
    assign bus.rvalid_o     = rvalid_q;
    assign bus.done_o       = done_q;
    assign bus.err_o        = err_q;
    assign bus.spi_we_o     = we_q;
    assign bus.spi_addr_o   = {28'h0, spi_addr_q};
    assign bus.spi_wdata_o  = spi_wdata_q;
endmodule

// File: tb/tb_spi_xfer_seq.sv
// tb_spi_xfer_seq: SPI master register model plus scoreboard checks of the transaction sequencer.
module tb_spi_xfer_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    spi_xfer_seq_if #(.LEN_W(8)) sif ();
    spi_xfer_seq #(.BUSY_TMO(15)) dut (.clk(clk), .rst(rst), .bus(sif));

    int checks = 0, failures = 0;
    logic [7:0] exp_mosi[$], miso_q[$], exp_rd[$];
    logic       exp_err[$];
    logic [7:0]  sdata, cur_miso;
    logic [31:0] sctrl;
    int tick, starts, polls, writes, ctrl_writes;
    int done_cnt, rd_seen, wready_cnt, we_in_rvalid;
    bit stuck = 1'b0;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        end
    endtask

    task automatic flag(input string n, input logic [31:0] act);
        checks++;
        failures++;
        $display("FAIL %s: got %0h with nothing expected", n, act);
    endtask

    // SPI master register block: busy rises 3 ticks after start, data lands 3 ticks before busy drops
    assign sif.spi_rdata_i = sif.spi_addr_o == 32'h8 ? {31'b0, !stuck && tick >= 3 && tick <= 10} :
                             sif.spi_addr_o == 32'h4 ? {24'b0, sdata} : sctrl;

    always @(negedge clk) begin
        if (rst) begin
            tick = 0;
            sdata = 8'h00;
            sctrl = 32'h0;
        end else begin
            if (tick != 0) begin
                if (tick == 8) sdata = cur_miso;
                tick = tick == 11 ? 0 : tick + 1;
            end
            if (!sif.spi_we_o && sif.spi_addr_o == 32'h8 && !sif.req_ready_o && !sif.done_o) polls++;
            if (sif.spi_we_o) begin
                writes++;
                if (sif.spi_addr_o == 32'h4) sdata = sif.spi_wdata_o[7:0];
                else if (sif.spi_addr_o == 32'h0) begin
                    sctrl = sif.spi_wdata_o;
                    ctrl_writes++;
                    if (sctrl[0]) begin
                        chk("ctrl_start", sctrl, 32'h0000_0109);
                        if (exp_mosi.size() == 0) flag("mosi_extra", {24'h0, sdata});
                        else chk("mosi", {24'h0, sdata}, {24'h0, exp_mosi.pop_front()});
                        cur_miso = miso_q.size() != 0 ? miso_q.pop_front() : 8'hFF;
                        tick = 1;
                        starts++;
                        polls = 0;
                    end else chk("ctrl_stop", sctrl, 32'h0000_0100);
                end else flag("spi_addr", sif.spi_addr_o);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (sif.rvalid_o && sif.rready_i) begin
                if (exp_rd.size() == 0) flag("rdata_extra", {24'h0, sif.rdata_o});
                else chk("rdata", {24'h0, sif.rdata_o}, {24'h0, exp_rd.pop_front()});
                rd_seen++;
            end
            if (sif.rvalid_o && sif.spi_we_o) we_in_rvalid++;
            if (sif.wready_o) wready_cnt++;
            if (sif.done_o) begin
                done_cnt++;
                if (exp_err.size() == 0) flag("done_extra", {31'b0, sif.err_o});
                else chk("err", {31'b0, sif.err_o}, {31'b0, exp_err.pop_front()});
                chk("ss_at_done", {31'b0, sctrl[3]}, 32'h0);
            end else if (sif.err_o) flag("err_without_done", 32'h1);
        end
    end

    task automatic issue(input logic [7:0] c, input logic ae, input logic [23:0] a,
                         input logic [3:0] d, input logic [7:0] wl, input logic [7:0] rl);
        int t = 0;
        while (!sif.req_ready_o && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        @(posedge clk); #1;
        sif.cmd_i = c; sif.addr_en_i = ae; sif.addr_i = a; sif.dummy_i = d;
        sif.wr_len_i = wl; sif.rd_len_i = rl; sif.req_valid_i = 1'b1;
        @(posedge clk); #1;
        sif.req_valid_i = 1'b0;
        sif.cmd_i = 8'h5C; sif.addr_en_i = ~ae; sif.addr_i = 24'hFFFFFF; sif.dummy_i = 4'hF;
        sif.wr_len_i = 8'hEE; sif.rd_len_i = 8'hEE;
    endtask

    task automatic wait_done(input int n);
        int t = 0;
        while (done_cnt < n && t < 6000) begin
            @(posedge clk); #1;
            t++;
        end
        chk("done_reached", {31'b0, done_cnt >= n}, 32'h1);
    endtask

    task automatic feed(input logic [7:0] d, input int stall);
        int t = 0;
        repeat (stall) @(posedge clk);
        #1;
        sif.wdata_i = d;
        sif.wvalid_i = 1'b1;
        do begin
            @(negedge clk);
            t++;
        end while (!sif.wready_o && t < 500);
        chk("wready_seen", {31'b0, sif.wready_o}, 32'h1);
        @(posedge clk); #1;
        sif.wvalid_i = 1'b0;
        sif.wdata_i = 8'h00;
    endtask

    task automatic push8(ref logic [7:0] q[$], input logic [63:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) q.push_back(v[i*8 +: 8]);
    endtask

    initial begin
        int base, w0, t;
        sif.req_valid_i = 1'b0; sif.cmd_i = 8'h0; sif.addr_en_i = 1'b0; sif.addr_i = 24'h0;
        sif.dummy_i = 4'h0; sif.wr_len_i = 8'h0; sif.rd_len_i = 8'h0; sif.wdata_i = 8'h0;
        sif.wvalid_i = 1'b0; sif.rready_i = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", {31'b0, sif.req_ready_o}, 32'h1);
        chk("rst_spi_addr", sif.spi_addr_o, 32'h8);
        chk("rst_outputs", {sif.spi_we_o, sif.done_o, sif.err_o, sif.rvalid_o, sif.wready_o}, 32'h0);
        chk("rst_wdata", sif.spi_wdata_o, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;

        push8(exp_mosi, 64'h9F000000, 4); push8(miso_q, 64'h11EF4018, 4);
        push8(exp_rd, 64'hEF4018, 3); exp_err.push_back(1'b0);
        issue(8'h9F, 1'b0, 24'h0, 4'h0, 8'd0, 8'd3);
        wait_done(1);

        push8(exp_mosi, 64'h03123456000000, 7); push8(miso_q, 64'h0000000000A1B2, 7);
        push8(exp_rd, 64'hA1B2, 2); exp_err.push_back(1'b0);
        issue(8'h03, 1'b1, 24'h123456, 4'h1, 8'd0, 8'd2);
        wait_done(2);

        push8(exp_mosi, 64'h02AAAAAAC35A, 6); exp_err.push_back(1'b0);
        base = wready_cnt;
        issue(8'h02, 1'b1, 24'hAAAAAA, 4'h0, 8'd2, 8'd0);
        feed(8'hC3, 70);
        feed(8'h5A, 10);
        wait_done(3);
        chk("wready_pulses", wready_cnt - base, 32'd2);

        push8(exp_mosi, 64'h0B00000000, 5); push8(miso_q, 64'h0001020304, 5);
        push8(exp_rd, 64'h01020304, 4); exp_err.push_back(1'b0);
        base = rd_seen;
        issue(8'h0B, 1'b0, 24'h0, 4'h0, 8'd0, 8'd4);
        t = 0;
        while (rd_seen == base && t < 500) begin
            @(posedge clk); #1;
            t++;
        end
        sif.rready_i = 1'b0;
        repeat (20) @(posedge clk);
        w0 = ctrl_writes;
        repeat (30) @(posedge clk);
        @(negedge clk);
        chk("stall_ctrl_writes", ctrl_writes - w0, 32'd0);
        chk("stall_rvalid", {31'b0, sif.rvalid_o}, 32'h1);
        chk("stall_rdata", {24'h0, sif.rdata_o}, 32'h02);
        @(posedge clk); #1;
        sif.rready_i = 1'b1;
        wait_done(4);

        stuck = 1'b1;
        exp_mosi.push_back(8'h05); exp_err.push_back(1'b1);
        issue(8'h05, 1'b0, 24'h0, 4'h0, 8'd0, 8'd1);
        wait_done(5);
        chk("abort_polls", polls, 32'd16);
        stuck = 1'b0;

        push8(exp_mosi, 64'h0B010203, 4);
        base = starts;
        issue(8'h0B, 1'b1, 24'h010203, 4'h0, 8'd0, 8'd0);
        t = 0;
        while (starts < base + 3 && t < 500) begin
            @(posedge clk); #1;
            t++;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_mosi.delete();
        miso_q.delete();
        @(negedge clk);
        chk("midrst_we", {31'b0, sif.spi_we_o}, 32'h0);
        chk("midrst_ready", {31'b0, sif.req_ready_o}, 32'h1);
        w0 = writes;
        repeat (20) @(posedge clk);
        chk("midrst_quiet", writes - w0, 32'd0);
        push8(exp_mosi, 64'h9F00, 2); push8(miso_q, 64'h1177, 2);
        exp_rd.push_back(8'h77); exp_err.push_back(1'b0);
        issue(8'h9F, 1'b0, 24'h0, 4'h0, 8'd0, 8'd1);
        wait_done(6);

        exp_mosi.push_back(8'h06); exp_err.push_back(1'b0);
        issue(8'h06, 1'b0, 24'h0, 4'h0, 8'd0, 8'd0);
        wait_done(7);

        exp_mosi.push_back(8'h3B); miso_q.push_back(8'h00); exp_err.push_back(1'b0);
        for (int i = 1; i <= 255; i++) begin
            exp_mosi.push_back(8'h00);
            miso_q.push_back(8'(i));
            exp_rd.push_back(8'(i));
        end
        issue(8'h3B, 1'b0, 24'h0, 4'h0, 8'd0, 8'd255);
        wait_done(8);

        repeat (5) @(posedge clk);
        chk("rd_left", exp_rd.size(), 32'd0);
        chk("mosi_left", exp_mosi.size(), 32'd0);
        chk("done_left", exp_err.size(), 32'd0);
        chk("done_count", done_cnt, 32'd8);
        chk("ctrl_write_while_rvalid", we_in_rvalid, 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
